// File: rtl/pulse_pkg.sv
// Shared pulse descriptor types used by the pulse merging FIFO and its memory.
package pulse_pkg;

  localparam int unsigned PULSE_TS_W  = 32;
  localparam int unsigned PULSE_LEN_W = 16;

  typedef struct packed {
    logic [PULSE_TS_W-1:0]  ts;
    logic [PULSE_LEN_W-1:0] length;
  } pulse_t;

endpackage

// File: rtl/pulse_fifo_mem.sv
// Simple dual-port pulse memory: synchronous write, registered read.
// The read register doubles as the FIFO output register, so it holds when rd_en is low.
module pulse_fifo_mem
  import pulse_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pulse_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output pulse_t        rd_data
);

  pulse_t mem [DEPTH];

  // Write port: storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port with synchronous clear of the output register.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multi_pulse_fifo.sv
// Merges pulse descriptors from N_INPUT valid/ready sources into one FIFO drained
// through a single first-word-fall-through valid/ready port.
module multi_pulse_fifo
  import pulse_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned N_INPUT = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_INPUT-1:0]              in_valid,
  input  logic [PULSE_TS_W*N_INPUT-1:0]   in_ts,
  input  logic [PULSE_LEN_W*N_INPUT-1:0]  in_length,
  output logic [N_INPUT-1:0]              in_ready,
  output logic                            out_valid,
  output logic [PULSE_TS_W-1:0]           out_ts,
  output logic [PULSE_LEN_W-1:0]          out_length,
  input  logic                            out_ready
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned IW         = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_INPUT - 1);

  logic [N_INPUT-1:0] stage_full;
  pulse_t             stage_data [N_INPUT];

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic          grant_valid;
  logic          wr_en;
  logic          rd_en;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  pulse_t        rd_data;

  assign in_ready = ~stage_full;
  assign wr_en    = grant_valid & (fifo_count < FULL_COUNT);
  assign rd_en    = (fifo_count != '0) & (~out_valid | out_ready);

  assign out_ts     = rd_data.ts;
  assign out_length = rd_data.length;

  // Round-robin search over full stages, starting at rr_ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < N_INPUT; off++) begin
      cand = IW'((32'(rr_ptr) + off) % N_INPUT);
      if (!grant_valid && stage_full[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Input stages: a stage drained on this edge does not reload until in_ready has risen.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_full <= '0;
    end else begin
      for (int unsigned i = 0; i < N_INPUT; i++) begin
        if (wr_en && (grant_idx == IW'(i))) begin
          stage_full[i] <= 1'b0;
        end else if (in_valid[i] && !stage_full[i]) begin
          stage_full[i]        <= 1'b1;
          stage_data[i].ts     <= in_ts[PULSE_TS_W*i +: PULSE_TS_W];
          stage_data[i].length <= in_length[PULSE_LEN_W*i +: PULSE_LEN_W];
        end
      end
    end
  end

  // FIFO pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rr_ptr     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output valid: set when the read register is loaded, cleared once the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset)          out_valid <= 1'b0;
    else if (rd_en)     out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  pulse_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (stage_data[grant_idx]),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_multi_pulse_fifo.sv
// Bench for multi_pulse_fifo: directed scenarios plus random traffic, checked
// against a queue-based transaction model of the merging FIFO.
module tb_multi_pulse_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NI    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NI-1:0] in_valid;
  logic [63:0]   in_ts;
  logic [31:0]   in_length;
  logic [NI-1:0] in_ready;
  logic          out_valid;
  logic [31:0]   out_ts;
  logic [15:0]   out_length;
  logic          out_ready;

  always #5 clk = ~clk;

  multi_pulse_fifo #(
    .DEPTH   (DEPTH),
    .N_INPUT (NI)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ts      (in_ts),
    .in_length  (in_length),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ts     (out_ts),
    .out_length (out_length),
    .out_ready  (out_ready)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_full [NI];
  logic [47:0] m_stage [NI];
  logic [47:0] m_q [$];
  bit          m_ov;
  logic [47:0] m_od;
  int unsigned m_rr;

  logic [47:0] pop_log [$];
  logic [NI-1:0] hs;
  int unsigned acc0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NI; c++) m_full[c] = 1'b0;
    m_q.delete();
    m_ov = 1'b0;
    m_od = '0;
    m_rr = 0;
  endtask

  // One clock edge of the transaction model, using the inputs currently driven.
  task automatic model_step();
    bit pop;
    int g;
    int unsigned c;
    logic [47:0] granted;
    if (reset) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && (!m_ov || out_ready);
    g = -1;
    granted = '0;
    if (m_q.size() < DEPTH) begin
      for (int unsigned k = 0; k < NI; k++) begin
        c = (m_rr + k) % NI;
        if (g < 0 && m_full[c]) g = int'(c);
      end
    end
    if (g >= 0) granted = m_stage[g];
    for (int s = 0; s < NI; s++) begin
      if (s == g) m_full[s] = 1'b0;
      else if (in_valid[s] && !m_full[s]) begin
        m_full[s]  = 1'b1;
        m_stage[s] = {in_ts[32*s +: 32], in_length[16*s +: 16]};
      end
    end
    if (pop) begin
      m_od = m_q.pop_front();
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (g >= 0) begin
      m_q.push_back(granted);
      m_rr = (int'(g) + 1) % NI;
    end
  endtask

  task automatic compare_outputs();
    logic [NI-1:0] exp_rdy;
    for (int c = 0; c < NI; c++) exp_rdy[c] = ~m_full[c];
    check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_val("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      check_val("out_ts", 64'(out_ts), 64'(m_od[47:16]));
      check_val("out_length", 64'(out_length), 64'(m_od[15:0]));
    end
  endtask

  // Called at the negedge with inputs already driven: log handshakes, clock, model, check.
  task automatic cycle();
    hs = in_valid & in_ready;
    if (hs[0]) acc0++;
    if (out_valid && out_ready) pop_log.push_back({out_ts, out_length});
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    in_valid  = '0;
    in_ts     = '0;
    in_length = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int unsigned n;
    int unsigned same;
    int unsigned acc_before;
    logic [47:0] e;

    reset = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    model_reset();

    // 1: reset and idle
    cycle();
    cycle();
    reset = 1'b0;
    check_val("rst_out_ts", 64'(out_ts), 64'h0);
    check_val("rst_out_length", 64'(out_length), 64'h0);
    check_val("rst_in_ready", 64'(in_ready), 64'h3);
    repeat (6) cycle();

    // 2: both channels valid in the same single cycle
    pop_log.delete();
    out_ready = 1'b1;
    in_valid  = 2'b11;
    in_ts     = {32'h22222222, 32'h11111111};
    in_length = {16'h2222, 16'h1111};
    cycle();
    idle_inputs();
    repeat (6) cycle();
    check_val("t2_count", 64'(pop_log.size()), 64'd2);
    e = (pop_log.size() > 0) ? pop_log[0] : '0;
    check_val("t2_first", 64'(e), 64'h111111111111);
    e = (pop_log.size() > 1) ? pop_log[1] : '0;
    check_val("t2_second", 64'(e), 64'h222222222222);

    // 3: stalled consumer, ch0 sends ts 1..10, then drain in order
    pop_log.delete();
    out_ready = 1'b0;
    n = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 20) out_ready = 1'b1;
      in_valid  = {1'b0, (n <= 10)};
      in_ts     = {32'h0, 32'(n)};
      in_length = {16'h0, 16'(n)};
      cycle();
      if (hs[0]) n++;
    end
    idle_inputs();
    check_val("t3_count", 64'(pop_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      e = (i < pop_log.size()) ? pop_log[i] : '0;
      check_val("t3_order", 64'(e[47:16]), 64'(i + 1));
    end
    check_val("t3_empty", 64'(out_valid), 64'h0);

    // 4: fill to capacity with ch0, then one pop admits exactly one new pulse
    do_reset();
    out_ready = 1'b0;
    acc0 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = 2'b01;
      in_ts     = {32'h0, 32'(cyc + 100)};
      in_length = {16'h0, 16'(cyc)};
      cycle();
    end
    check_val("t4_accepts", 64'(acc0), 64'(DEPTH + 2));
    check_val("t4_ready_low", 64'(in_ready[0]), 64'h0);
    acc_before = acc0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    repeat (10) cycle();
    check_val("t4_one_more", 64'(acc0 - acc_before), 64'd1);

    // 5: both channels continuously valid, grants alternate
    do_reset();
    pop_log.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      in_valid  = 2'b11;
      in_ts     = {32'h80000000 | 32'(cyc), 32'(cyc)};
      in_length = {16'(cyc), 16'(cyc)};
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();
    same = 0;
    for (int i = 1; i < pop_log.size(); i++)
      if (pop_log[i][47] == pop_log[i-1][47]) same++;
    check_val("t5_alternate", 64'(same), 64'd0);
    e = (pop_log.size() > 0) ? pop_log[0] : '1;
    check_val("t5_first_ch0", 64'(e[47]), 64'h0);

    // 6: reset while partly full with a pulse presented
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid  = 2'b11;
      in_ts     = {32'(cyc + 500), 32'(cyc + 400)};
      in_length = {16'(cyc), 16'(cyc)};
      cycle();
    end
    check_val("t6_pre_valid", 64'(out_valid), 64'h1);
    reset = 1'b1;
    cycle();
    check_val("t6_valid_cleared", 64'(out_valid), 64'h0);
    check_val("t6_ready_all", 64'(in_ready), 64'h3);
    reset = 1'b0;
    idle_inputs();
    out_ready = 1'b1;
    repeat (5) cycle();
    check_val("t6_stays_empty", 64'(out_valid), 64'h0);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset     = ($urandom_range(0, 499) == 0);
      in_valid  = NI'($urandom);
      in_ts     = {$urandom, $urandom};
      in_length = {16'($urandom), 16'($urandom)};
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
